debounce_capture: RTL and testbench

//  Upstream conditioning stage for the 4-bit assertion gate (in[0]-qualified pass-through).
//  - Synchronises asynchronous raw switch/pin inputs and debounces them as a vector.
//  - Commits a new registered value only after it has been stable long enough.
//  - Drives the gate's 4-bit input and pulses out_valid once per commit.

---
 rtl/debounce_capture_pkg.sv | 19 +
 rtl/debounce_capture_if.sv | 38 +++
 rtl/debounce_capture_sync_chain.sv | 31 +++
 rtl/debounce_capture.sv | 120 ++++++++++++
 tb/tb_debounce_capture.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/debounce_capture_pkg.sv
// Shared definitions for the debounce_capture block: FSM state encoding,
// default geometry and the width of the optional commit counter.
package debounce_pkg;

    // Controller states; busy is simply "state is not ST_IDLE".
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int DEF_WIDTH           = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

    // Width of the saturating commit counter (DBC_CHANGE_COUNT_EN builds).
    localparam int CHG_CNT_W = 8;

endpackage

// File: rtl/debounce_capture_if.sv
// Signal bundle between the raw-pin side and the debounce_capture block.
// The slave modport is the debouncer; the master modport drives raw_in and
// observes the committed value. change_cnt exists only when
// DBC_CHANGE_COUNT_EN is defined.
interface debounce_capture_if
    import debounce_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0]     raw_in;
    logic [WIDTH-1:0]     out;
    logic                 out_valid;
    logic                 busy;
`ifdef DBC_CHANGE_COUNT_EN
    logic [CHG_CNT_W-1:0] change_cnt;
`endif

    modport slave (
        input  raw_in,
        output out,
        output out_valid,
`ifdef DBC_CHANGE_COUNT_EN
        output change_cnt,
`endif
        output busy
    );

    modport master (
        output raw_in,
        input  out,
        input  out_valid,
`ifdef DBC_CHANGE_COUNT_EN
        input  change_cnt,
`endif
        input  busy
    );

endinterface

// File: rtl/debounce_capture_sync_chain.sv
// Multi-flop synchroniser for the asynchronous raw input vector.
// Every stage resets to zero; only the last stage is meant to be used.
module sync_chain #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // Shift the raw vector through SYNC_STAGES flops to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_capture.sv
// debounce_capture: synchronises and debounces a raw input vector, committing
// a new value to out only after it has been stable for DEBOUNCE_CYCLES
// consecutive cycles, with a one-cycle out_valid pulse per commit.
// Optional feature macro: DBC_CHANGE_COUNT_EN adds a saturating 8-bit count
// of commits on change_cnt.
module debounce_capture
    import debounce_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    debounce_capture_if.slave  bus
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] candidate_q;
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    state_t           state_q;
    logic             commit_now;

    sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.raw_in),
        .q_o (s)
    );

    // The candidate has survived the full window and is still different from out.
    assign commit_now = (state_q == ST_SETTLE) && (s != out_q) &&
                        (s == candidate_q) && (cnt_q == CNT_MAX);

    // Settle/commit controller with the stability counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            candidate_q <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s != out_q) begin
                        candidate_q <= s;
                        cnt_q       <= CNT_ONE;
                        state_q     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (s == out_q) begin
                        // Input bounced back to the committed value: abandon.
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (s != candidate_q) begin
                        // Any bit moving restarts the window for the whole vector.
                        candidate_q <= s;
                        cnt_q       <= CNT_ONE;
                    end else if (commit_now) begin
                        out_q       <= candidate_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_COMMIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_COMMIT: begin
                    // One dead cycle after a commit; s is deliberately ignored.
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != ST_IDLE);

`ifdef DBC_CHANGE_COUNT_EN
    logic [CHG_CNT_W-1:0] change_cnt_q;
    logic [CHG_CNT_W-1:0] change_cnt_d;

    // Saturating increment on every commit.
    always_comb begin
        change_cnt_d = change_cnt_q;
        if (commit_now && (change_cnt_q != {CHG_CNT_W{1'b1}})) begin
            change_cnt_d = change_cnt_q + CHG_CNT_W'(1);
        end
    end

    // Commit counter register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            change_cnt_q <= '0;
        end else begin
            change_cnt_q <= change_cnt_d;
        end
    end

    assign bus.change_cnt = change_cnt_q;
`endif

endmodule

// File: tb/tb_debounce_capture.sv
// Directed bench for debounce_capture (WIDTH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Expected commits (value and edge number) are queued
// when stimulus is driven; a monitor pops and checks them on each out_valid.
module tb_debounce_capture;
    import debounce_pkg::*;

    typedef struct {
        logic [3:0] val;
        int         at_edge;
    } exp_t;

    logic clk;
    logic rst;
    int   edge_n;
    int   checks;
    int   errors;
    int   n_commits;
    int   exp_commits;
    int   e0;
    int   e1;
    exp_t sb[$];

    debounce_capture_if #(.WIDTH(4)) bus ();

    debounce_capture #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so commit timing can be expressed in edge numbers.
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic to_edge(input int k);
        while (edge_n < k) @(negedge clk);
    endtask

    task automatic expect_commit(input logic [3:0] v, input int at);
        exp_t e;
        e.val     = v;
        e.at_edge = at;
        sb.push_back(e);
        exp_commits++;
    endtask

    initial begin
        edge_n      = 0;
        checks      = 0;
        errors      = 0;
        n_commits   = 0;
        exp_commits = 0;
        rst         = 1'b1;
        bus.raw_in  = 4'hF;

        fork
            begin : monitor
                logic prev_v;
                exp_t e;
                prev_v = 1'b0;
                forever begin
                    @(negedge clk);
                    if (bus.out_valid === 1'b1) begin
                        n_commits++;
                        check("valid_not_back_to_back", 32'(prev_v), 0);
                        if (sb.size() == 0) begin
                            check("unexpected_commit", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            check("commit_value", 32'(bus.out), 32'(e.val));
                            check("commit_edge", edge_n, e.at_edge);
                        end
                    end
                    prev_v = bus.out_valid;
                end
            end
        join_none

        // 1. Reset with raw_in all ones, then quiet release.
        repeat (3) @(negedge clk);
        check("reset_out", 32'(bus.out), 0);
        check("reset_valid", 32'(bus.out_valid), 0);
        check("reset_busy", 32'(bus.busy), 0);
`ifdef DBC_CHANGE_COUNT_EN
        check("reset_change_cnt", 32'(bus.change_cnt), 0);
`endif
        bus.raw_in = 4'h0;
        rst        = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_out", 32'(bus.out), 0);
        check("idle_busy", 32'(bus.busy), 0);

        // 2. Clean change 0 -> A.
        e0 = edge_n;
        bus.raw_in = 4'hA;
        expect_commit(4'hA, e0 + 7);
        to_edge(e0 + 2);
        check("clean_busy_e2", 32'(bus.busy), 0);
        to_edge(e0 + 3);
        check("clean_busy_e3", 32'(bus.busy), 1);
        to_edge(e0 + 6);
        check("clean_busy_e6", 32'(bus.busy), 1);
        check("clean_out_e6", 32'(bus.out), 0);
        to_edge(e0 + 7);
        check("clean_busy_e7", 32'(bus.busy), 1);
        check("clean_out_e7", 32'(bus.out), 32'h A);
        to_edge(e0 + 8);
        check("clean_busy_e8", 32'(bus.busy), 0);
        check("clean_valid_e8", 32'(bus.out_valid), 0);
        repeat (4) @(negedge clk);

        // 3. Bounce restart: 6 for 2 cycles, 2 for 1, then 6 held.
        e0 = edge_n;
        bus.raw_in = 4'h6;
        repeat (2) @(negedge clk);
        bus.raw_in = 4'h2;
        @(negedge clk);
        bus.raw_in = 4'h6;
        e1 = edge_n;
        expect_commit(4'h6, e1 + 7);
        to_edge(e1 + 10);
        check("bounce_out", 32'(bus.out), 32'h6);
        check("bounce_busy", 32'(bus.busy), 0);

        // Establish out = 3.
        e0 = edge_n;
        bus.raw_in = 4'h3;
        expect_commit(4'h3, e0 + 7);
        to_edge(e0 + 10);
        check("set3_out", 32'(bus.out), 32'h3);
`ifdef DBC_CHANGE_COUNT_EN
        check("change_cnt_3", 32'(bus.change_cnt), 3);
`endif

        // 4. Bounce-back glitch: 1 for 2 cycles, back to 3.
        e0 = edge_n;
        bus.raw_in = 4'h1;
        repeat (2) @(negedge clk);
        bus.raw_in = 4'h3;
        to_edge(e0 + 4);
        check("glitch_busy_settle", 32'(bus.busy), 1);
        to_edge(e0 + 5);
        check("glitch_busy_idle", 32'(bus.busy), 0);
        to_edge(e0 + 12);
        check("glitch_out", 32'(bus.out), 32'h3);

        // 5. Reset during SETTLE, then a full commit after release.
        e0 = edge_n;
        bus.raw_in = 4'h5;
        to_edge(e0 + 5);
        check("mid_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("async_rst_out", 32'(bus.out), 0);
        check("async_rst_busy", 32'(bus.busy), 0);
        check("async_rst_valid", 32'(bus.out_valid), 0);
`ifdef DBC_CHANGE_COUNT_EN
        check("async_rst_change_cnt", 32'(bus.change_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        e1 = edge_n;
        expect_commit(4'h5, e1 + 7);
        to_edge(e1 + 6);
        check("post_rst_out_e6", 32'(bus.out), 0);
        to_edge(e1 + 7);
        check("post_rst_out_e7", 32'(bus.out), 32'h5);
        to_edge(e1 + 9);
        check("post_rst_busy", 32'(bus.busy), 0);

`ifdef DBC_CHANGE_COUNT_EN
        // 6. Saturation of the commit counter.
        check("change_cnt_1", 32'(bus.change_cnt), 1);
        for (int i = 0; i < 300; i++) begin
            logic [3:0] v;
            v = (i % 2 == 0) ? 4'h9 : 4'h5;
            e0 = edge_n;
            bus.raw_in = v;
            expect_commit(v, e0 + 7);
            to_edge(e0 + 9);
            if (i == 252) check("change_cnt_fe", 32'(bus.change_cnt), 32'hFE);
            if (i == 253) check("change_cnt_ff", 32'(bus.change_cnt), 32'hFF);
        end
        check("change_cnt_hold", 32'(bus.change_cnt), 32'hFF);
`endif

        repeat (12) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("commit_total", n_commits, exp_commits);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
